// File: rtl/exc_ctrl.sv
// Exception sequencer and CP0 register holder (STATUS, CAUSE, EPC).
// Arbitrates WB exceptions, interrupts and eret, then runs a fixed
// IDLE -> FLUSH -> REDIRECT handshake with fetch.
module exc_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [2:0]  wb_excvec,
  input  logic [31:0] wb_pc,
  input  logic        wb_bd,
  input  logic        wb_eret,
  input  logic [5:0]  int_req,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  input  logic        if_ready,
  output logic        flush,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        exl
);

  localparam logic [31:0] STATUS_WMASK = 32'h0040_FF07;
  localparam logic [4:0]  CODE_INT     = 5'h00;
  localparam logic [4:0]  CODE_RI      = 5'h0A;
  localparam logic [4:0]  CODE_SYS     = 5'h08;
  localparam logic [4:0]  CODE_OV      = 5'h0C;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;

  state_t                      state;
  logic [SYNC_STAGES-1:0][5:0] int_sync;

  logic        idle, exc_sync, irq, evt, do_eret;
  logic [4:0]  exc_code;
  logic [31:0] vec, int_base;

  assign exl = status[1];

  // Multi-flop synchroniser on the asynchronous interrupt lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_sync <= '0;
    end else begin
      int_sync[0] <= int_req;
      for (int i = 1; i < SYNC_STAGES; i++) int_sync[i] <= int_sync[i-1];
    end
  end

  // Event arbitration: sync exceptions beat interrupts, eret is last
  always_comb begin
    idle     = (state == IDLE);
    exc_sync = |wb_excvec;
    irq      = (|(cause[15:8] & status[15:8])) & status[0] & ~status[1] & ~status[2];
    evt      = idle & wb_valid & (exc_sync | irq);
    do_eret  = idle & wb_valid & ~exc_sync & ~irq & wb_eret;
    if (wb_excvec[2])      exc_code = CODE_OV;
    else if (wb_excvec[1]) exc_code = CODE_SYS;
    else if (wb_excvec[0]) exc_code = CODE_RI;
    else                   exc_code = CODE_INT;
    int_base = status[22] ? 32'hBFC0_0000 : 32'h8000_0000;
    if (exc_sync) vec = status[22] ? 32'hBFC0_0380 : 32'h8000_0180;
    else          vec = int_base + (cause[23] ? 32'h0000_0200 : 32'h0000_0180);
  end

  // CP0 read mux, no same-cycle bypass of a pending mtc0
  always_comb begin
    case (cp0_raddr)
      5'd12:   cp0_rdata = status;
      5'd13:   cp0_rdata = cause;
      5'd14:   cp0_rdata = epc;
      default: cp0_rdata = 32'h0;
    endcase
  end

  // Sequencer FSM with registered outputs; also owns the CP0 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      flush       <= 1'b0;
      stall       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= 32'h0;
      status      <= 32'h0040_0000;
      cause       <= 32'h0;
      epc         <= 32'h0;
    end else begin
      // hardware IP bits track the synchroniser in every state
      cause[15:10] <= int_sync[SYNC_STAGES-1];
      case (state)
        IDLE: begin
          if (evt) begin
            state       <= FLUSH;
            flush       <= 1'b1;
            stall       <= 1'b1;
            redirect_pc <= vec;
            cause[6:2]  <= exc_code;
            status[1]   <= 1'b1;
            // nested exception inside a handler keeps the original return point
            if (!status[1]) begin
              epc       <= wb_bd ? wb_pc - 32'd4 : wb_pc;
              cause[31] <= wb_bd;
            end
          end else if (do_eret) begin
            state       <= FLUSH;
            flush       <= 1'b1;
            stall       <= 1'b1;
            redirect_pc <= epc;
            status[1]   <= 1'b0;
          end else if (cp0_we) begin
            case (cp0_waddr)
              5'd12: status <= (status & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
              5'd13: begin
                cause[23]  <= cp0_wdata[23];
                cause[9:8] <= cp0_wdata[9:8];
              end
              5'd14: epc <= cp0_wdata;
              default: ;
            endcase
          end
        end
        FLUSH: begin
          state    <= REDIR;
          flush    <= 1'b0;
          redirect <= 1'b1;
        end
        REDIR: begin
          if (if_ready) begin
            state    <= IDLE;
            redirect <= 1'b0;
            stall    <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          flush    <= 1'b0;
          redirect <= 1'b0;
          stall    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Sequencer and CP0 state holder for the exception path of the pipelined MIPS CPU. It owns the STATUS, CAUSE and EPC registers, and latches and synchronises the six hardware interrupt lines. It arbitrates between writeback-stage exceptions, interrupts and `eret`, then drives the flush/redirect handshake with fetch. It sits beside the writeback stage and replaces ad-hoc combinational vectoring with a registered, cycle-defined sequence.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on each `int_req` line (minimum 2).
- Clock is `clk`; reset is `rst_n`, asynchronous, active-low.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `wb_valid`  in  1  a real instruction occupies WB this cycle
- `wb_excvec`  in  3  bit0 unknown instr, bit1 syscall, bit2 overflow
- `wb_pc`  in  32  PC of WB instruction
- `wb_bd`  in  1  WB instruction sits in a branch delay slot
- `wb_eret`  in  1  WB instruction is `eret`
- `int_req`  in  6  asynchronous level interrupt requests (HW IP7..IP2)
- `cp0_we`  in  1  mtc0 write strobe (WB)
- `cp0_waddr`  in  5  write register number
- `cp0_wdata`  in  32  write data
- `cp0_raddr`  in  5  read register number
- `cp0_rdata`  out  32  combinational read: 12 STATUS, 13 CAUSE, 14 EPC, others 0
- `if_ready`  in  1  fetch accepts redirect this cycle
- `flush`  out  1  kill all pipeline stages
- `stall`  out  1  freeze pipeline while sequence active
- `redirect`  out  1  redirect request to fetch
- `redirect_pc`  out  32  target PC, registered
- `status`, `cause`, `epc`  out  32 each  current register values
- `exl`  out  1  STATUS[1]

## Operation
- STATUS bits used: IE[0], EXL[1], ERL[2], IM[15:8], BEV[22]. CAUSE bits used: ExcCode[6:2], IP[15:8], IV[23], BD[31].
- Reset values:
  - STATUS = 32'h0040_0000 (BEV=1); CAUSE = 0; EPC = 0; state IDLE.
  - flush, stall, redirect = 0; redirect_pc = 0; synchroniser flops = 0.
- CAUSE.IP[15:10] is loaded every cycle from the synchronised `int_req[5:0]` and is read-only. CAUSE.IP[9:8] is software-writable.
- mtc0 writable fields:
  - STATUS: [22], [15:8], [2:0].
  - CAUSE: [23], [9:8].
  - EPC: all bits.
  - All other bits are read-only and remain 0.
- Events are evaluated only in IDLE and only when `wb_valid` = 1. Priority order:
  - Overflow: ExcCode 0x0C.
  - Syscall: ExcCode 0x08.
  - Unknown instruction: ExcCode 0x0A.
  - Interrupt: ExcCode 0x00. Taken when |(IP[15:8] & IM[15:8]) & IE & ~EXL & ~ERL.
  - eret: lowest priority.
- On taking an exception or interrupt:
  - ExcCode updated; EXL set.
  - If EXL was 0 beforehand: EPC = `wb_bd` ? `wb_pc`−4 : `wb_pc`, and BD = `wb_bd`. If EXL was 1 (synchronous exception inside a handler), EPC and BD are left unchanged.
  - The WB instruction is cancelled, so its mtc0 write is dropped.
- Vector selection:
  - Synchronous exceptions: BEV ? 32'hBFC0_0380 : 32'h8000_0180.
  - Interrupts: (BEV ? 32'hBFC0_0000 : 32'h8000_0000) + (IV ? 32'h200 : 32'h180).
- On eret: EXL is cleared and redirect_pc = EPC. An mtc0 in the same cycle is impossible (same instruction) and is ignored.
- State machine:
  - IDLE → FLUSH on exception, interrupt or eret; CP0 registers and redirect_pc are updated at that edge.
  - FLUSH → REDIRECT unconditionally.
  - REDIRECT → IDLE on the cycle `if_ready` = 1; otherwise hold.
- Output decode: `flush` = (state == FLUSH); `redirect` = (state == REDIRECT); `stall` = (state != IDLE).
- Outside IDLE, all WB inputs and mtc0 writes are ignored. `int_req` keeps being sampled into IP in every state.

## Timing
- Event sampled at edge T. At T+1: state FLUSH, registers hold new values, `flush` = 1. At T+2: `redirect` = 1 with a stable `redirect_pc`.
- Minimum latency from event to fetch acceptance is 2 cycles; the bound is otherwise set by `if_ready`.
- `redirect_pc` must not change while `redirect` = 1.
- Interrupt latency from an `int_req` edge to IP visibility is SYNC_STAGES+1 cycles. The interrupt is taken at the first following cycle with `wb_valid` = 1 in IDLE.
- mtc0 writes become visible on `cp0_rdata` the cycle after the write edge; there is no same-cycle bypass.
- Asserting `rst_n` low at any point forces IDLE and all reset values immediately. A pending redirect is discarded.

## Test plan
- Overflow at `wb_pc`=0x0040_0010, `wb_bd`=0, BEV=0:
  - EPC=0x0040_0010, ExcCode=0x0C, EXL=1.
  - `flush` high 1 cycle, then `redirect_pc`=0x8000_0180.
- Syscall with `wb_bd`=1, `wb_pc`=0x0040_0024:
  - EPC=0x0040_0020, BD=1.
  - With `if_ready` held low for 3 cycles, `redirect` stays high 4 cycles with a stable PC.
- mtc0 STATUS=0x0000_0401 (IE=1, IM[10]=1, BEV=0), CAUSE IV=1, then `int_req[0]`=1:
  - After sync, with `wb_valid`=1: ExcCode=0, CAUSE[10]=1, `redirect_pc`=0x8000_0200.
  - With IE=0 instead: no event.
- Overflow and syscall flagged together while EXL=1:
  - ExcCode=0x0C.
  - EPC and BD unchanged.
  - Redirect to 0x8000_0180.
- eret with EPC=0x0040_0100: EXL cleared, `redirect_pc`=0x0040_0100.
- Reset during REDIRECT: `redirect`, `stall` and `flush` drop to 0 asynchronously and STATUS reads back 0x0040_0000.
